// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and the hex to 7-segment table for seg_scan_mux.
// Patterns are active-low: bit 0 = a .. bit 6 = g, bit 7 = dp.
package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [6:0] SEG_OFF7  = 7'h7F;

    localparam int SEG_A  = 0;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    typedef enum logic {
        PH_BLANK,
        PH_DRIVE
    } phase_e;

    // 0-9, A, b, C, d, E, F
    localparam logic [6:0] HEX7_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        return HEX7_TABLE[nib];
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: nibble + blank + decimal point to active-low segment byte.
// A blanked digit keeps its decimal point.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o              = SEG_BLANK;
        seg_o[SEG_G:SEG_A] = blank_i ? SEG_OFF7 : hex7(nibble_i);
        seg_o[SEG_DP]      = ~dp_i;
    end

endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: N-digit common-anode scanner with frame snapshot and LZ blanking.
// Define SEG_DIMMING_EN to add the brightness port and PWM on the anodes.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 16384,
    parameter int BLANK_CYC  = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    lz_blank,
`ifdef SEG_DIMMING_EN
    input  logic [3:0]              brightness,
`endif
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    localparam logic [DW-1:0] DIV_LAST  = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] BLANK_END = DW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = '1;
    localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

    logic [DW-1:0]              div_cnt_q, div_cnt_d;
    logic [IW-1:0]              idx_q, idx_d;
    logic [NUM_DIGITS-1:0][3:0] snap_dig_q, snap_dig_d;
    logic [NUM_DIGITS-1:0]      snap_dp_q, snap_dp_d;
    logic                       snap_lz_q, snap_lz_d;
    logic [7:0]                 seg_q, seg_d;
    logic [NUM_DIGITS-1:0]      an_q, an_d;
    logic                       fs_q, fs_d;

    logic                  tick;
    logic                  wrap;
    logic                  lit;
    phase_e                phase;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic [7:0]            dec_seg;

    assign tick = (div_cnt_q == DIV_LAST);
    assign wrap = tick && (idx_q == IDX_LAST);

    always_comb begin
        div_cnt_d  = tick ? '0 : div_cnt_q + 1'b1;
        idx_d      = idx_q;
        snap_dig_d = snap_dig_q;
        snap_dp_d  = snap_dp_q;
        snap_lz_d  = snap_lz_q;
        fs_d       = wrap;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end
        // Inputs are only sampled at the frame boundary so a frame never tears.
        if (wrap) begin
            snap_dig_d = digits;
            snap_dp_d  = dp;
            snap_lz_d  = lz_blank;
        end
    end

    always_comb begin : lz_scan
        logic zero_run;
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            zero_run   = zero_run & (snap_dig_q[k] == 4'h0);
            lz_mask[k] = zero_run & snap_lz_q;
        end
    end

    seg_hex_decode u_dec (
        .nibble_i (snap_dig_q[idx_q]),
        .blank_i  (lz_mask[idx_q]),
        .dp_i     (snap_dp_q[idx_q]),
        .seg_o    (dec_seg)
    );

    assign phase = (div_cnt_q < BLANK_END) ? PH_BLANK : PH_DRIVE;

`ifdef SEG_DIMMING_EN
    assign lit = (div_cnt_q[3:0] <= brightness);
`else
    assign lit = 1'b1;
`endif

    always_comb begin
        seg_d = SEG_BLANK;
        an_d  = AN_OFF;
        if (enable && phase == PH_DRIVE) begin
            seg_d = dec_seg;
            if (lit) begin
                an_d = ~(AN_ONE << idx_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q  <= '0;
            idx_q      <= '0;
            snap_dig_q <= '0;
            snap_dp_q  <= '0;
            snap_lz_q  <= 1'b0;
            seg_q      <= SEG_BLANK;
            an_q       <= AN_OFF;
            fs_q       <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            idx_q      <= idx_d;
            snap_dig_q <= snap_dig_d;
            snap_dp_q  <= snap_dp_d;
            snap_lz_q  <= snap_lz_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
            fs_q       <= fs_d;
        end
    end

    assign seg         = seg_q;
    assign an          = an_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: directed bench for seg_scan_mux at N=4, SCAN_DIV=32, BLANK_CYC=4.
// Define SEG_DIMMING_EN to include the brightness scenario.
module tb_seg_scan_mux;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        lz_blank;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_start;
`ifdef SEG_DIMMING_EN
    logic [3:0]  brightness;
`endif

    int checks   = 0;
    int failures = 0;
    int br       = 15;

    // Expected segment bytes per frame, packed {digit3, digit2, digit1, digit0}
    localparam logic [31:0] EXP_1234 = {8'hF9, 8'hA4, 8'hB0, 8'h99};
    localparam logic [31:0] EXP_DP   = {8'hF9, 8'h24, 8'hB0, 8'h19};
    localparam logic [31:0] EXP_1111 = {8'hF9, 8'hF9, 8'hF9, 8'hF9};
    localparam logic [31:0] EXP_2222 = {8'hA4, 8'hA4, 8'hA4, 8'hA4};
    localparam logic [31:0] EXP_ZERO = {8'hC0, 8'hC0, 8'hC0, 8'hC0};

    localparam logic [15:0] LZ_DIG [4] = '{16'h0070, 16'h0000, 16'h0000, 16'h0A00};
    localparam logic [3:0]  LZ_DP  [4] = '{4'b0000, 4'b0000, 4'b1000, 4'b0000};
    localparam logic [31:0] LZ_EXP [4] = '{
        {8'hFF, 8'hFF, 8'hF8, 8'hC0},
        {8'hFF, 8'hFF, 8'hFF, 8'hC0},
        {8'h7F, 8'hFF, 8'hFF, 8'hC0},
        {8'hFF, 8'h88, 8'hC0, 8'hC0}
    };

    seg_scan_mux #(
        .NUM_DIGITS (4),
        .SCAN_DIV   (32),
        .BLANK_CYC  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .digits      (digits),
        .dp          (dp),
        .lz_blank    (lz_blank),
`ifdef SEG_DIMMING_EN
        .brightness  (brightness),
`endif
        .seg         (seg),
        .an          (an),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // j = edges since the frame_start edge; output at edge j shows cycle j-1
    function automatic logic [3:0] m_an(input int j, input int b);
        int pos;
        int slot;
        logic [3:0] one;
        pos  = (j - 1) % 32;
        slot = ((j - 1) / 32) % 4;
        one  = 4'b0001;
        if (pos < 4 || (pos % 16) > b) return 4'hF;
        return ~(one << slot);
    endfunction

    function automatic logic [7:0] m_seg(input int j, input logic [31:0] e);
        int pos;
        int slot;
        pos  = (j - 1) % 32;
        slot = ((j - 1) / 32) % 4;
        if (pos < 4) return 8'hFF;
        return e[slot*8 +: 8];
    endfunction

    task automatic wait_frame(input int limit, output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        while (!ok && n < limit) begin
            @(posedge clk);
            #1;
            n++;
            if (frame_start === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        enable   = 1'b1;
        digits   = 16'h1234;
        dp       = 4'b0000;
        lz_blank = 1'b0;
`ifdef SEG_DIMMING_EN
        brightness = 4'd15;
`endif
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (an !== 4'hF) begin
            failures++;
            $display("FAIL reset_an got=%b want=1111", an);
        end
        checks++;
        if (seg !== 8'hFF) begin
            failures++;
            $display("FAIL reset_seg got=%h want=ff", seg);
        end
        checks++;
        if (frame_start !== 1'b0) begin
            failures++;
            $display("FAIL reset_fs got=%b want=0", frame_start);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_scan;
        bit ok;
        int n;
        logic [3:0] ea;
        logic [7:0] es;
        wait_frame(300, ok, n);
        checks++;
        if (!ok || n != 128) begin
            failures++;
            $display("FAIL first_frame got=%0d(ok=%0d) want=128", n, ok);
        end
        for (int j = 1; j <= 128; j++) begin
            @(posedge clk);
            #1;
            ea = m_an(j, br);
            es = m_seg(j, EXP_1234);
            checks++;
            if (an !== ea || seg !== es || frame_start !== (j == 128)) begin
                failures++;
                $display("FAIL scan_1234 j=%0d got an=%b seg=%h fs=%b want an=%b seg=%h fs=%0d",
                         j, an, seg, frame_start, ea, es, j == 128);
            end
        end
    endtask

    task automatic test_dp;
        bit ok;
        int n;
        logic [3:0] ea;
        logic [7:0] es;
        dp = 4'b0101;
        wait_frame(300, ok, n);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL dp_wait got=timeout want=frame_start");
        end
        for (int j = 1; j <= 128; j++) begin
            @(posedge clk);
            #1;
            ea = m_an(j, br);
            es = m_seg(j, EXP_DP);
            checks++;
            if (an !== ea || seg !== es) begin
                failures++;
                $display("FAIL dp j=%0d got an=%b seg=%h want an=%b seg=%h",
                         j, an, seg, ea, es);
            end
        end
    endtask

    task automatic test_lz;
        bit ok;
        int n;
        logic [3:0] ea;
        logic [7:0] es;
        lz_blank = 1'b1;
        for (int v = 0; v < 4; v++) begin
            digits = LZ_DIG[v];
            dp     = LZ_DP[v];
            wait_frame(300, ok, n);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL lz_wait v=%0d got=timeout want=frame_start", v);
            end
            for (int j = 1; j <= 128; j++) begin
                @(posedge clk);
                #1;
                ea = m_an(j, br);
                es = m_seg(j, LZ_EXP[v]);
                checks++;
                if (an !== ea || seg !== es) begin
                    failures++;
                    $display("FAIL lz v=%0d j=%0d got an=%b seg=%h want an=%b seg=%h",
                             v, j, an, seg, ea, es);
                end
            end
        end
        lz_blank = 1'b0;
        dp       = 4'b0000;
    endtask

    task automatic test_tear;
        bit ok;
        int n;
        logic [3:0] ea;
        logic [7:0] es;
        digits = 16'h1111;
        wait_frame(300, ok, n);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL tear_wait got=timeout want=frame_start");
        end
        for (int j = 1; j <= 256; j++) begin
            @(posedge clk);
            #1;
            ea = m_an(j, br);
            es = m_seg(j, (j <= 128) ? EXP_1111 : EXP_2222);
            checks++;
            if (an !== ea || seg !== es ||
                frame_start !== (j == 128 || j == 256)) begin
                failures++;
                $display("FAIL tear j=%0d got an=%b seg=%h fs=%b want an=%b seg=%h",
                         j, an, seg, frame_start, ea, es);
            end
            if (j == 70) digits = 16'h2222;
        end
    endtask

    task automatic test_enable;
        bit ok;
        int n;
        logic [3:0] ea;
        logic [7:0] es;
        digits = 16'h1234;
        wait_frame(300, ok, n);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL en_wait got=timeout want=frame_start");
        end
        for (int j = 1; j <= 128; j++) begin
            @(posedge clk);
            #1;
            ea = m_an(j, br);
            es = m_seg(j, EXP_1234);
            if (j >= 41 && j <= 90) begin
                ea = 4'hF;
                es = 8'hFF;
            end
            checks++;
            if (an !== ea || seg !== es || frame_start !== (j == 128)) begin
                failures++;
                $display("FAIL enable j=%0d got an=%b seg=%h fs=%b want an=%b seg=%h",
                         j, an, seg, frame_start, ea, es);
            end
            if (j == 40) enable = 1'b0;
            if (j == 90) enable = 1'b1;
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int n;
        logic [3:0] ea;
        logic [7:0] es;
        wait_frame(300, ok, n);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rmid_wait got=timeout want=frame_start");
        end
        repeat (50) @(posedge clk);
        #4;
        rst = 1'b1;
        #1;
        checks++;
        if (an !== 4'hF || seg !== 8'hFF || frame_start !== 1'b0) begin
            failures++;
            $display("FAIL rst_async got an=%b seg=%h fs=%b want an=1111 seg=ff fs=0",
                     an, seg, frame_start);
        end
        @(posedge clk);
        #1;
        checks++;
        if (an !== 4'hF || seg !== 8'hFF) begin
            failures++;
            $display("FAIL rst_hold got an=%b seg=%h want an=1111 seg=ff", an, seg);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int j = 1; j <= 128; j++) begin
            @(posedge clk);
            #1;
            ea = m_an(j, br);
            es = m_seg(j, EXP_ZERO);
            checks++;
            if (an !== ea || seg !== es || frame_start !== (j == 128)) begin
                failures++;
                $display("FAIL rst_restart j=%0d got an=%b seg=%h fs=%b want an=%b seg=%h",
                         j, an, seg, frame_start, ea, es);
            end
        end
    endtask

`ifdef SEG_DIMMING_EN
    task automatic test_dimming;
        bit ok;
        int n;
        logic [3:0] ea;
        logic [7:0] es;
        brightness = 4'd3;
        br         = 3;
        wait_frame(300, ok, n);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL dim_wait got=timeout want=frame_start");
        end
        for (int j = 1; j <= 128; j++) begin
            @(posedge clk);
            #1;
            ea = m_an(j, br);
            es = m_seg(j, EXP_1234);
            checks++;
            if (an !== ea || seg !== es) begin
                failures++;
                $display("FAIL dim j=%0d got an=%b seg=%h want an=%b seg=%h",
                         j, an, seg, ea, es);
            end
        end
        brightness = 4'd15;
        br         = 15;
    endtask
`endif

    initial begin
        test_reset();
        test_scan();
        test_dp();
        test_lz();
        test_tear();
        test_enable();
        test_reset_mid();
`ifdef SEG_DIMMING_EN
        test_dimming();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
